// File: rtl/block_dispatcher.sv
// Kernel launcher: splits a kernel's threads into fixed-size blocks, issues them
// to idle compute cores and raises done once every block has been completed.
module block_dispatcher #(
    parameter int NUM_CORES         = 2,
    parameter int THREADS_PER_BLOCK = 4
) (
    input  logic                                               clk,
    input  logic                                               reset,
    input  logic                                               start,
    input  logic [7:0]                                         thread_count,
    output logic                                               done,
    output logic [NUM_CORES-1:0]                               core_start,
    input  logic [NUM_CORES-1:0]                               core_done,
    output logic [NUM_CORES-1:0][7:0]                          core_block_id,
    output logic [NUM_CORES-1:0][$clog2(THREADS_PER_BLOCK):0]  core_thread_count
);
    localparam int SHIFT = $clog2(THREADS_PER_BLOCK);
    localparam int TCW   = SHIFT + 1;

    typedef enum logic [1:0] {IDLE, LAUNCH, RUN, DONE} state_e;

    state_e                         state_q, state_d;
    logic [7:0]                     count_q, total_q, disp_q, compl_q, compl_d;
    logic [NUM_CORES-1:0]           busy_q, busy_d, cstart_q;
    logic [NUM_CORES-1:0][7:0]      bid_q;
    logic [NUM_CORES-1:0][TCW-1:0]  btc_q;

    logic [NUM_CORES-1:0]           pick, comp;
    logic [7:0]                     ncomp;
    logic [8:0]                     blocks_sum;
    logic [15:0]                    offset, remain;
    logic [TCW-1:0]                 blk_tc;
    logic                           can_disp;

    // Block count is a ceiling divide done in 9 bits so 255+TPB-1 cannot overflow.
    assign blocks_sum = {1'b0, count_q} + 9'(THREADS_PER_BLOCK - 1);
    assign offset     = 16'(disp_q) * 16'(THREADS_PER_BLOCK);
    assign remain     = 16'(count_q) - offset;
    assign blk_tc     = (remain >= 16'(THREADS_PER_BLOCK)) ? TCW'(THREADS_PER_BLOCK)
                                                           : remain[TCW-1:0];
    assign can_disp   = (state_q == RUN) && (disp_q < total_q);

    // A done level seen while start is still pulsing is stale from the previous block.
    assign comp = (state_q == RUN) ? (busy_q & core_done & ~cstart_q) : '0;

    always_comb begin
        pick = '0;
        for (int i = NUM_CORES - 1; i >= 0; i--) begin
            if (!busy_q[i]) pick = NUM_CORES'(1) << i;
        end
        if (!can_disp) pick = '0;
    end

    always_comb begin
        ncomp = '0;
        for (int i = 0; i < NUM_CORES; i++) ncomp = ncomp + 8'(comp[i]);
    end

    assign busy_d  = (busy_q & ~comp) | pick;
    assign compl_d = compl_q + ncomp;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) state_q <= IDLE;
        else        state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (start) state_d = LAUNCH;
            LAUNCH:  state_d = RUN;
            RUN:     if (compl_q == total_q) state_d = DONE;
            DONE:    if (!start) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        done = (state_q == DONE);
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            count_q  <= '0;
            total_q  <= '0;
            disp_q   <= '0;
            compl_q  <= '0;
            busy_q   <= '0;
            cstart_q <= '0;
            bid_q    <= '0;
            btc_q    <= '0;
        end else begin
            cstart_q <= pick;
            busy_q   <= busy_d;
            if (state_q == IDLE && start) begin
                count_q <= thread_count;
                disp_q  <= '0;
                compl_q <= '0;
            end else begin
                compl_q <= compl_d;
                if (|pick) disp_q <= disp_q + 8'd1;
            end
            if (state_q == LAUNCH) total_q <= 8'(blocks_sum >> SHIFT);
            for (int i = 0; i < NUM_CORES; i++) begin
                if (pick[i]) begin
                    bid_q[i] <= disp_q;
                    btc_q[i] <= blk_tc;
                end
            end
        end
    end

    assign core_start        = cstart_q;
    assign core_block_id     = bid_q;
    assign core_thread_count = btc_q;

endmodule

// File: tb/tb_block_dispatcher.sv
// Directed bench for block_dispatcher (2 cores, 4 threads per block); core_done is
// driven by hand to emulate cores, including stale done levels across blocks.
module tb_block_dispatcher;
    logic            clk = 1'b0;
    logic            reset;
    logic            start;
    logic [7:0]      thread_count;
    logic            done;
    logic [1:0]      core_start;
    logic [1:0]      core_done;
    logic [1:0][7:0] core_block_id;
    logic [1:0][2:0] core_thread_count;

    int n_run  = 0;
    int n_fail = 0;

    block_dispatcher #(.NUM_CORES(2), .THREADS_PER_BLOCK(4)) dut (
        .clk               (clk),
        .reset             (reset),
        .start             (start),
        .thread_count      (thread_count),
        .done              (done),
        .core_start        (core_start),
        .core_done         (core_done),
        .core_block_id     (core_block_id),
        .core_thread_count (core_thread_count)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_run++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(negedge clk);
    endtask

    task automatic wait_pulse(input string tag, input int maxc);
        int n = 0;
        while (core_start == 2'b00 && n < maxc) begin
            tick();
            n++;
        end
        chk({tag, "_pulse_seen"}, 32'(core_start != 2'b00), 32'd1);
    endtask

    task automatic wait_done(input string tag, input int maxc);
        int n = 0;
        while (!done && n < maxc) begin
            tick();
            n++;
        end
        chk({tag, "_done"}, 32'(done), 32'd1);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        logic bad;
        logic seen;

        // reset state
        reset = 1'b0; start = 1'b0; thread_count = 8'd0; core_done = 2'b00;
        repeat (3) tick();
        chk("rst_done",  32'(done), 32'd0);
        chk("rst_cs",    32'(core_start), 32'd0);
        chk("rst_id",    32'(core_block_id), 32'd0);
        chk("rst_tc",    32'(core_thread_count), 32'd0);
        reset = 1'b1;
        tick();

        // 8 threads: two full blocks, both cores finish together
        thread_count = 8'd8; start = 1'b1;
        tick();
        wait_pulse("s1", 8);
        chk("s1_cs0",  32'(core_start), 32'd1);
        chk("s1_id0",  32'(core_block_id[0]), 32'd0);
        chk("s1_tc0",  32'(core_thread_count[0]), 32'd4);
        tick();
        chk("s1_cs1",  32'(core_start), 32'd2);
        chk("s1_id1",  32'(core_block_id[1]), 32'd1);
        chk("s1_tc1",  32'(core_thread_count[1]), 32'd4);
        tick();
        chk("s1_cs_none", 32'(core_start), 32'd0);
        core_done = 2'b11;
        chk("s1_pre_done", 32'(done), 32'd0);
        wait_done("s1", 4);
        tick();
        chk("s1_done_hold", 32'(done), 32'd1);
        start = 1'b0;
        tick();
        chk("s1_done_drop", 32'(done), 32'd0);

        // 10 threads with done levels still high from the last kernel
        thread_count = 8'd10; start = 1'b1;
        tick();
        wait_pulse("s4", 8);
        chk("s4_cs0", 32'(core_start), 32'd1);
        chk("s4_id0", 32'(core_block_id[0]), 32'd0);
        chk("s4_tc0", 32'(core_thread_count[0]), 32'd4);
        tick();
        chk("s4_cs1", 32'(core_start), 32'd2);
        chk("s4_id1", 32'(core_block_id[1]), 32'd1);
        chk("s4_tc1", 32'(core_thread_count[1]), 32'd4);
        core_done[0] = 1'b0;
        tick();
        core_done[1] = 1'b0;
        chk("s4_cs_none", 32'(core_start), 32'd0);
        bad = 1'b0;
        for (int i = 0; i < 3; i++) begin
            tick();
            if (core_start != 2'b00 || done) bad = 1'b1;
        end
        chk("s4_no_false_compl", 32'(bad), 32'd0);

        // core 1 finishes first and receives the partial third block
        core_done[1] = 1'b1;
        tick();
        chk("s2_gap", 32'(core_start), 32'd0);
        tick();
        chk("s2_cs1",      32'(core_start), 32'd2);
        chk("s2_id1",      32'(core_block_id[1]), 32'd2);
        chk("s2_tc1",      32'(core_thread_count[1]), 32'd2);
        chk("s2_id0_hold", 32'(core_block_id[0]), 32'd0);
        chk("s2_tc0_hold", 32'(core_thread_count[0]), 32'd4);
        tick();
        core_done[1] = 1'b0;
        chk("s2_cs_none", 32'(core_start), 32'd0);
        core_done[0] = 1'b1;
        repeat (3) tick();
        chk("s2_not_done", 32'(done), 32'd0);
        chk("s2_no_extra", 32'(core_start), 32'd0);
        core_done[1] = 1'b1;
        wait_done("s2", 5);
        start = 1'b0;
        tick();
        chk("s2_done_drop", 32'(done), 32'd0);

        // zero threads: no blocks, straight to done
        core_done = 2'b00; thread_count = 8'd0; start = 1'b1;
        bad = 1'b0; seen = 1'b0;
        for (int i = 0; i < 4; i++) begin
            tick();
            if (core_start != 2'b00) bad = 1'b1;
            if (done) seen = 1'b1;
        end
        chk("s3_no_pulse", 32'(bad), 32'd0);
        chk("s3_done",     32'(seen), 32'd1);
        start = 1'b0;
        tick();
        chk("s3_done_drop", 32'(done), 32'd0);

        // reset mid-run with one block still outstanding
        thread_count = 8'd8; start = 1'b1;
        tick();
        wait_pulse("s6", 8);
        tick();
        chk("s6_cs1", 32'(core_start), 32'd2);
        tick();
        core_done[0] = 1'b1;
        repeat (2) tick();
        #2 reset = 1'b0;
        #1;
        chk("s6_rst_done", 32'(done), 32'd0);
        chk("s6_rst_cs",   32'(core_start), 32'd0);
        chk("s6_rst_id",   32'(core_block_id), 32'd0);
        chk("s6_rst_tc",   32'(core_thread_count), 32'd0);
        core_done = 2'b00; start = 1'b0;
        tick();
        reset = 1'b1;
        tick();
        chk("s6_idle", 32'(done), 32'd0);
        thread_count = 8'd4; start = 1'b1;
        tick();
        wait_pulse("s6b", 8);
        chk("s6b_cs0", 32'(core_start), 32'd1);
        chk("s6b_id0", 32'(core_block_id[0]), 32'd0);
        chk("s6b_tc0", 32'(core_thread_count[0]), 32'd4);
        tick();
        chk("s6b_cs_none", 32'(core_start), 32'd0);
        repeat (3) tick();
        chk("s6b_no_more",  32'(core_start), 32'd0);
        chk("s6b_not_done", 32'(done), 32'd0);
        core_done[0] = 1'b1;
        wait_done("s6b", 5);
        start = 1'b0;
        tick();
        chk("s6b_done_drop", 32'(done), 32'd0);

        $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
        $finish;
    end
endmodule
